// File: rtl/lcd_host.sv
// lcd_host: issues commands to the 12x9 LCD controller, streams the image ROM on a load
// and captures the 16 refreshed pixels. Define LCD_HOST_CHK_EN to build the timeout and pixel-count checks.
module lcd_host #(
   parameter int IMG_BYTES = 108,
   parameter int TIMEOUT   = 255
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_valid,
   input  logic [3:0] req_cmd,
   output logic       req_ready,
   output logic [6:0] img_addr,
   input  logic [7:0] img_rd_data,
   output logic [3:0] cmd,
   output logic       cmd_valid,
   output logic [7:0] datain,
   input  logic       busy,
   input  logic [7:0] dataout,
   input  logic       output_valid,
   input  logic [3:0] res_addr,
   output logic [7:0] res_data,
   output logic       frame_done,
   output logic [2:0] err
);

   localparam logic [6:0] LAST_ADDR = 7'(IMG_BYTES - 1);
   localparam logic [3:0] MAX_CODE  = 4'd8;
   localparam logic [4:0] NUM_PIX   = 5'd16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_LOAD,
      S_WAIT,
      S_DONE
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cmd_q, cmd_d;
   logic [6:0] img_addr_q, img_addr_d;
   logic [4:0] pix_cnt_q, pix_cnt_d;
   logic       seen_busy_q, seen_busy_d;
   logic       err0_q, err0_d;
   logic       res_we;
   logic       cmd_valid_c;
   logic       frame_done_c;
   logic [7:0] res_buf_q [16];

`ifdef LCD_HOST_CHK_EN
   localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT);
   logic [7:0] timer_q, timer_d;
   logic       timed_out_q, timed_out_d;
   logic       err1_q, err1_d;
   logic       err2_q, err2_d;
`endif

   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      img_addr_d   = img_addr_q;
      pix_cnt_d    = pix_cnt_q;
      seen_busy_d  = seen_busy_q;
      err0_d       = err0_q;
      res_we       = 1'b0;
      cmd_valid_c  = 1'b0;
      frame_done_c = 1'b0;
`ifdef LCD_HOST_CHK_EN
      timer_d      = timer_q;
      timed_out_d  = timed_out_q;
      err1_d       = err1_q;
      err2_d       = err2_q;
`endif
      case (state_q)
         S_IDLE: begin
            img_addr_d = '0;
            if (req_valid) begin
               if (req_cmd > MAX_CODE) begin
                  err0_d = 1'b1;
               end else begin
                  cmd_d   = req_cmd;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            img_addr_d  = '0;
            pix_cnt_d   = '0;
            seen_busy_d = 1'b0;
`ifdef LCD_HOST_CHK_EN
            timer_d     = '0;
            timed_out_d = 1'b0;
`endif
            // A controller still busy from a previous command holds off the strobe.
            if (!busy) begin
               cmd_valid_c = 1'b1;
               if (cmd_q == 4'd0) begin
                  state_d    = S_LOAD;
                  img_addr_d = 7'd1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_LOAD: begin
            if (img_addr_q == LAST_ADDR) begin
               img_addr_d = '0;
               state_d    = S_WAIT;
            end else begin
               img_addr_d = img_addr_q + 7'd1;
            end
         end
         S_WAIT: begin
            if (busy) seen_busy_d = 1'b1;
            if (output_valid && (pix_cnt_q < NUM_PIX)) begin
               res_we    = 1'b1;
               pix_cnt_d = pix_cnt_q + 5'd1;
            end
            if (seen_busy_q && !busy) state_d = S_DONE;
`ifdef LCD_HOST_CHK_EN
            timer_d = timer_q + 8'd1;
            if (timer_d == TIMEOUT_VAL) begin
               err1_d      = 1'b1;
               timed_out_d = 1'b1;
               state_d     = S_DONE;
            end
`endif
         end
         S_DONE: begin
            frame_done_c = 1'b1;
`ifdef LCD_HOST_CHK_EN
            if ((pix_cnt_q != NUM_PIX) && !timed_out_q) err2_d = 1'b1;
`endif
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cmd_q       <= '0;
         img_addr_q  <= '0;
         pix_cnt_q   <= '0;
         seen_busy_q <= 1'b0;
         err0_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         img_addr_q  <= img_addr_d;
         pix_cnt_q   <= pix_cnt_d;
         seen_busy_q <= seen_busy_d;
         err0_q      <= err0_d;
      end
   end

`ifdef LCD_HOST_CHK_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timer_q     <= '0;
         timed_out_q <= 1'b0;
         err1_q      <= 1'b0;
         err2_q      <= 1'b0;
      end else begin
         timer_q     <= timer_d;
         timed_out_q <= timed_out_d;
         err1_q      <= err1_d;
         err2_q      <= err2_d;
      end
   end
   assign err = {err2_q, err1_q, err0_q};
`else
   assign err = {2'b00, err0_q};
`endif

   // Entries not written by the current capture keep their previous contents.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 16; i++) res_buf_q[i] <= '0;
      end else if (res_we) begin
         res_buf_q[pix_cnt_q[3:0]] <= dataout;
      end
   end

   assign req_ready  = (state_q == S_IDLE) && reset_n;
   assign cmd_valid  = cmd_valid_c;
   assign cmd        = cmd_q;
   assign img_addr   = img_addr_q;
   assign datain     = img_rd_data;
   assign frame_done = frame_done_c;
   assign res_data   = res_buf_q[res_addr];

endmodule

// File: doc/lcd_host.md
# lcd_host

Command initiator and frame collector for the 12x9-pixel LCD controller. It accepts host requests, issues single-cycle commands on the controller's `cmd`/`cmd_valid` interface, and streams the 108-byte image from a synchronous image ROM during a load. It captures the 16 refreshed output pixels into a local result buffer. It sits between the test or system sequencer and the LCD controller and is the driving end of the controller's command/data protocol.

## Interface
- `IMG_BYTES`, 108: bytes streamed per load command.
- `TIMEOUT`, 255: maximum cycles in WAIT before a timeout error (8-bit counter).
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request strobe from sequencer.
- `req_cmd`  in  4  requested command code (0 = load, 1–8 = rotate/zoom/shift).
- `req_ready`  out  1  high only in IDLE.
- `img_addr`  out  7  image ROM address (registered).
- `img_rd_data`  in  8  ROM data, valid one cycle after `img_addr`.
- `cmd`  out  4  command to controller.
- `cmd_valid`  out  1  command strobe, one cycle per command.
- `datain`  out  8  wired directly from `img_rd_data`.
- `busy`  in  1  controller busy.
- `dataout`  in  8  controller pixel output.
- `output_valid`  in  1  controller pixel strobe.
- `res_addr`  in  4  result-buffer read address.
- `res_data`  out  8  result-buffer byte (combinational read).
- `frame_done`  out  1  one-cycle pulse at end of each command.
- `err`  out  3  sticky: bit0 illegal command, bit1 timeout, bit2 pixel-count mismatch.

## Operation
States are IDLE, ISSUE, LOAD, WAIT and DONE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch `req_cmd`.
  - Codes 9–15 set `err[0]`, are dropped, and the block stays in IDLE with no `frame_done`.
  - Legal codes go to ISSUE.
  - `img_addr` is held at 0.
- **ISSUE** (one cycle)
  - `cmd_valid`=1, `cmd`=latched code, `img_addr`=0.
  - Clear `pix_cnt`, `seen_busy` and the timer.
  - Code 0 goes to LOAD; all others go to WAIT.
- **LOAD**
  - `img_addr` increments 1..IMG_BYTES-1, one per cycle.
  - After the cycle with `img_addr`=107, go to WAIT.
- **WAIT**
  - `seen_busy` is set on `busy`=1.
  - On each `output_valid`, write `dataout` to `res_buf[pix_cnt]` and increment `pix_cnt`, saturating at 16. Writes after the 16th are dropped.
  - When `seen_busy` is set and `busy`=0, go to DONE. The pixel strobed in that same cycle is captured.
  - The timer increments every cycle. When the timer reaches TIMEOUT, set `err[1]` and go to DONE.
- **DONE** (one cycle)
  - `frame_done`=1.
  - If `pix_cnt`≠16 and no timeout occurred, set `err[2]`.
  - Go to IDLE.
- `cmd_valid` is never asserted while `busy`=1 or outside ISSUE.
- Result buffer contents persist until overwritten by the next command's capture. Pixels that were not written keep their old values.

## Timing
- Reset values: `req_ready`=0 during reset, then 1 in IDLE. `cmd`=0, `cmd_valid`=0, `img_addr`=0, `frame_done`=0, `err`=0, `res_buf` all 0, state IDLE.
- A request accepted in cycle A gives `cmd_valid` in cycle A+1 (T0).
- For a load, the ROM is addressed with k at T0+k. `datain` carries image byte k at T0+1+k, which is the controller's sampling cycle for byte k.
- `frame_done` occurs one cycle after the first cycle in which `busy`=0 follows a seen `busy`=1.
- Minimum spacing between consecutive `cmd_valid` pulses is 3 cycles after `busy` falls (DONE, IDLE, ISSUE).
- Reset mid-operation: everything returns to reset values immediately. `cmd_valid` drops asynchronously and any partial capture is discarded.
- `req_valid` outside IDLE is ignored and not queued.

## Configuration
- `LCD_HOST_CHK_EN` defined: the timeout counter and the pixel-count check are built, and `err[2:1]` behave as described.
- Not defined: the timer and the count compare are removed. `err[2:1]` are tied to 0, and WAIT exits only on the `busy` falling edge. `err[0]` is always present.

## Test plan
- Reset, then `req_cmd`=0 with ROM[k]=k: `datain`=k at T0+1+k for k=0..107. With the controller model active, `frame_done` follows 16 captures and `res_buf`[0..15] equals the 4x4 window bytes starting at address 13.
- `req_cmd`=3 (zoom in) after a load: one `cmd_valid` pulse, 16 bytes captured, `frame_done`, `err`=0.
- `req_cmd`=9: no `cmd_valid`, `err`=3'b001, and `req_ready` stays 1.
- Model holds `busy`=1 forever (CHK_EN defined): `err[1]` is set 255 cycles after WAIT entry and `frame_done` pulses once.
- Model emits only 15 `output_valid` pulses: `err[2]`=1 at DONE.
- `reset_n` asserted at `img_addr`=50 during a load: all outputs return to reset values and the next load restarts at `img_addr`=0.
